// File: rtl/banked_mem_responder.sv
// Memory-side responder: four word-interleaved banks, each with its own busy
// window, stall on bank conflict, and fixed-latency read return.
module banked_mem_responder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH_W   = 10,
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int CW = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
  localparam int MW = DEPTH_W + 2;

  logic [1:0]         bank;
  logic [DEPTH_W-1:0] idx;
  logic [MW-1:0]      maddr;
  logic               req;
  logic               legal;
  logic               accept;
  logic [CW-1:0]      cnt [4];
  logic [DATA_W-1:0]  mem [1 << MW];
  logic [RD_LAT-1:0]  vpipe;
  logic [DATA_W-1:0]  dpipe [RD_LAT];
  logic               unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:DEPTH_W+3];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  // Requests seen during reset are neither accepted nor stalled.
  always_comb begin
    bank   = addr[2:1];
    idx    = addr[DEPTH_W+2:3];
    maddr  = {bank, idx};
    req    = rd | wr;
    legal  = ~(rd & wr) & ~addr[0];
    stall  = req & legal & busy[bank] & ~rst;
    accept = req & legal & ~busy[bank] & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accept && (bank == 2'(i))) begin
          cnt[i] <= CW'(BANK_BUSY - 1);
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= req & ~legal;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[maddr] <= data_in;
    end
  end

  // Non-read slots carry zero so data_out is already zero whenever rd_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        dpipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= accept & rd;
      dpipe[0] <= (accept && rd) ? mem[maddr] : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign data_out = dpipe[RD_LAT-1];
  assign rd_valid = vpipe[RD_LAT-1];

endmodule
